imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Hardware boot loader that fills the CPU's 256x32 instruction memory from a byte stream, then releases the CPU.
- Accepts a length-prefixed, checksummed byte stream over a valid/ready handshake.
- Packs bytes into 32-bit words and writes them sequentially into instruction memory.
- Zero-fills the unused words, then asserts start_o, which drives the CPU's start_i.
- Replaces the preload-and-start sequence with synthesizable logic at the CPU top level.

Parameters:
- DEPTH, 256, number of instruction memory words; must be a power of two.
- ADDR_W, 8, instruction memory word address width; equals log2(DEPTH).
- TIMEOUT, 1024, maximum idle cycles between bytes once a load has begun.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset. One clock; reset is asynchronous and active-low.
- rx_data_i  in  8  stream byte.
- rx_valid_i  in  1  rx_data_i is valid.
- rx_ready_o  out  1  loader can accept a byte this cycle.
- imem_we_o  out  1  instruction memory write strobe, one cycle per word.
- imem_addr_o  out  ADDR_W  instruction memory word address.
- imem_data_o  out  32  instruction memory write data.
- start_o  out  1  CPU start; held high once the load succeeds.
- busy_o  out  1  load in progress (RECV, CHECK or FILL).
- error_o  out  1  load failed; sticky until reset.
- err_code_o  out  2  00 none, 01 checksum mismatch, 10 timeout.

Behaviour:
- Reset (asynchronous assert, synchronous release): state WAIT_LEN.
  - All outputs 0 except rx_ready_o=1.
  - Internal word count, byte index, checksum and timeout counter cleared.
- Byte transfer occurs on a posedge where rx_valid_i && rx_ready_o.
  - rx_ready_o=1 only in WAIT_LEN, RECV and CHECK.
  - rx_ready_o is a function of state only; it has no combinational path from rx_valid_i.
- Stream format: L, then 4*(L+1) data bytes, each word MSB first, then C.
  - L gives the word count N=L+1, so N ranges 1..256.
  - C is the XOR of all data bytes; L is not included in the XOR.
- WAIT_LEN: accepting L latches N and moves to RECV. No timeout in this state.
- RECV: bytes shift into the word register and are XORed into the checksum.
  - On the 4th byte of word k: the next cycle shows imem_we_o=1, imem_addr_o=k and the assembled word, for exactly one cycle.
  - A byte arriving that same cycle is accepted normally; the word register is double-buffered by the write stage.
  - After word N-1's 4th byte, move to CHECK.
- CHECK: accepting C compares it with the running XOR.
  - Match: go to FILL, or to RUN directly if N==DEPTH.
  - Mismatch: go to ERROR with err_code 01.
- FILL: one write per cycle, imem_we_o=1, data 0, address N..DEPTH-1 ascending.
  - The last write is at address DEPTH-1; the cycle after it, go to RUN.
- RUN: start_o=1 (registered), busy_o=0. Stays here until reset; further bytes are not accepted.
- ERROR: error_o=1 and err_code_o hold their value, start_o=0. Stays here until reset.
  - Words already written are not erased.
- Timeout applies in RECV and CHECK only.
  - The counter clears on each accepted byte and increments otherwise.
  - When it reaches TIMEOUT, go to ERROR with err_code 10.
- Address arithmetic: the write address counter is ADDR_W bits. FILL terminates on count==DEPTH-1 and never wraps.
- Reset mid-load: everything restarts from WAIT_LEN. start_o drops asynchronously.

Decomposition:
- Shared package imem_loader_pkg holds:
  - state enum: WAIT_LEN, RECV, CHECK, FILL, RUN, ERROR;
  - error code constants: ERR_NONE, ERR_CSUM, ERR_TIMEOUT.
- One sub-module, byte_word_packer: 4-byte shift register, byte index, word-ready pulse, running XOR.
- FSM, address counter and timeout counter live in imem_loader.

Test Plan:
- Basic load. Stimulus: L=0x01, bytes 8C 01 00 00 20 02 00 05, C=0xAA, rx_valid_i held high.
  - Writes addr0=0x8C010000 and addr1=0x20020005.
  - Then 254 zero writes to addresses 2..255.
  - start_o rises the cycle after the addr255 write; busy_o falls at the same edge.
- Full depth. Stimulus: L=0xFF, 1024 bytes with word k = k, correct C.
  - 256 writes, no FILL cycles, start_o=1 and no write to address 0 after the load.
- Bad checksum. Stimulus: same as the basic load but C=0xAB.
  - Ends with error_o=1, err_code_o=01, start_o never 1.
  - Words 0 and 1 are written; no zero-fill occurs.
- Timeout. Stimulus: L=0x00, then 3 data bytes, then valid low for 1024 cycles.
  - ERROR with err_code_o=10, rx_ready_o=0.
  - Holding valid low for 1023 cycles and then sending the 4th byte completes the load normally.
- Backpressure and gaps. Stimulus: rx_valid_i toggled randomly during the basic load.
  - Identical write sequence, start_o=1.
  - No byte is accepted in FILL or RUN, even with valid held high.
- Reset mid-FILL. Stimulus: assert rst_n_i low at FILL address 100, then release it.
  - All outputs return to reset values immediately.
  - A fresh basic load afterwards completes correctly.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state and error-code definitions for the boot loader
package imem_loader_pkg;

   typedef enum logic [2:0] {
      WAIT_LEN,
      RECV,
      CHECK,
      FILL,
      RUN,
      ERROR
   } state_t;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_CSUM    = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/imem_loader_byte_word_packer.sv
// rtl/imem_loader_byte_word_packer.sv - packs MSB-first bytes into 32-bit words and keeps the running XOR
module byte_word_packer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  byte_data,
   input  logic        byte_en,
   output logic [31:0] word,
   output logic        word_done,
   output logic [7:0]  csum
);

   logic [23:0] shift;
   logic [1:0]  idx;

   // The completed word includes the byte being accepted right now, so the
   // write stage can capture it on the same edge without waiting a cycle.
   assign word      = {shift, byte_data};
   assign word_done = byte_en && (idx == 2'd3);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift <= '0;
         idx   <= '0;
         csum  <= '0;
      end else if (byte_en) begin
         shift <= {shift[15:0], byte_data};
         idx   <= idx + 2'd1;
         csum  <= csum ^ byte_data;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads instruction memory from a checksummed byte stream, zero-fills, then starts the CPU
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int DEPTH   = 256,
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic [7:0]        rx_data_i,
   input  logic              rx_valid_i,
   output logic              rx_ready_o,
   output logic              imem_we_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   output logic [31:0]       imem_data_o,
   output logic              start_o,
   output logic              busy_o,
   output logic              error_o,
   output logic [1:0]        err_code_o
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [TW-1:0]     IDLE_MAX  = TW'(TIMEOUT - 1);

   state_t            state;
   logic [ADDR_W-1:0] last_word;
   logic [ADDR_W-1:0] word_cnt;
   logic [TW-1:0]     idle_cnt;
   logic              accept;
   logic              byte_en;
   logic              word_done;
   logic [31:0]       word;
   logic [7:0]        csum;

   assign rx_ready_o = (state == WAIT_LEN) || (state == RECV) || (state == CHECK);
   assign busy_o     = (state == RECV) || (state == CHECK) || (state == FILL);
   assign accept     = rx_valid_i && rx_ready_o;
   assign byte_en    = accept && (state == RECV);

   byte_word_packer u_packer (
      .clk       (clk_i),
      .rst_n     (rst_n_i),
      .byte_data (rx_data_i),
      .byte_en   (byte_en),
      .word      (word),
      .word_done (word_done),
      .csum      (csum)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state       <= WAIT_LEN;
         last_word   <= '0;
         word_cnt    <= '0;
         idle_cnt    <= '0;
         imem_we_o   <= 1'b0;
         imem_addr_o <= '0;
         imem_data_o <= '0;
         start_o     <= 1'b0;
         error_o     <= 1'b0;
         err_code_o  <= ERR_NONE;
      end else begin
         imem_we_o <= 1'b0;
         case (state)
            WAIT_LEN: begin
               if (accept) begin
                  last_word <= ADDR_W'(rx_data_i);
                  word_cnt  <= '0;
                  idle_cnt  <= '0;
                  state     <= RECV;
               end
            end
            RECV, CHECK: begin
               if (accept) begin
                  idle_cnt <= '0;
                  if (state == RECV) begin
                     if (word_done) begin
                        imem_we_o   <= 1'b1;
                        imem_addr_o <= word_cnt;
                        imem_data_o <= word;
                        word_cnt    <= word_cnt + ADDR_W'(1);
                        if (word_cnt == last_word) state <= CHECK;
                     end
                  end else if (rx_data_i != csum) begin
                     state      <= ERROR;
                     error_o    <= 1'b1;
                     err_code_o <= ERR_CSUM;
                  end else if (last_word == LAST_ADDR) begin
                     state   <= RUN;
                     start_o <= 1'b1;
                  end else begin
                     // First fill write goes out on this edge so FILL shows one write per cycle.
                     state       <= FILL;
                     imem_we_o   <= 1'b1;
                     imem_addr_o <= word_cnt;
                     imem_data_o <= '0;
                  end
               end else if (idle_cnt == IDLE_MAX) begin
                  state      <= ERROR;
                  error_o    <= 1'b1;
                  err_code_o <= ERR_TIMEOUT;
               end else begin
                  idle_cnt <= idle_cnt + TW'(1);
               end
            end
            FILL: begin
               if (imem_addr_o == LAST_ADDR) begin
                  state   <= RUN;
                  start_o <= 1'b1;
               end else begin
                  imem_we_o   <= 1'b1;
                  imem_addr_o <= imem_addr_o + ADDR_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - table-driven self-checking bench for imem_loader
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic        imem_we;
   logic [7:0]  imem_addr;
   logic [31:0] imem_data;
   logic        start;
   logic        busy;
   logic        error;
   logic [1:0]  err_code;

   imem_loader #(.DEPTH(256), .ADDR_W(8), .TIMEOUT(1024)) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .rx_data_i   (rx_data),
      .rx_valid_i  (rx_valid),
      .rx_ready_o  (rx_ready),
      .imem_we_o   (imem_we),
      .imem_addr_o (imem_addr),
      .imem_data_o (imem_data),
      .start_o     (start),
      .busy_o      (busy),
      .error_o     (error),
      .err_code_o  (err_code)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] len;
      logic [7:0] c;
      bit         gaps;
      bit         exp_start;
      logic [1:0] exp_code;
      int         exp_writes;
   } vec_t;

   vec_t vecs[5];
   int   total = 0;
   int   passed = 0;

   int          cyc = 0;
   logic [7:0]  wa[$];
   logic [31:0] wd[$];
   int          acc_cnt, last_we_cyc, start_cyc;
   bit          start_seen, busy_at_we, busy_at_start;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (imem_we) begin
         wa.push_back(imem_addr);
         wd.push_back(imem_data);
         last_we_cyc = cyc;
         busy_at_we  = busy;
      end
      if (rx_valid && rx_ready) acc_cnt++;
      if (start && !start_seen) begin
         start_seen    = 1'b1;
         start_cyc     = cyc;
         busy_at_start = busy;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [31:0] word_of(input logic [7:0] len, input int k);
      if (len == 8'h01) return (k == 0) ? 32'h8C010000 : 32'h20020005;
      return 32'(k);
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      rx_valid = 1'b0;
      rx_data = 8'h00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      wa.delete();
      wd.delete();
      acc_cnt = 0;
      start_seen = 1'b0;
      last_we_cyc = 0;
      start_cyc = 0;
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      bit ok = 1'b0;
      if (gaps) begin
         rx_valid = 1'b0;
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      rx_data  = b;
      rx_valid = 1'b1;
      for (int i = 0; i < 64 && !ok; i++) begin
         @(negedge clk);
         if (rx_ready) ok = 1'b1;
         @(posedge clk);
         #1;
      end
      if (!ok) begin
         total++;
         $display("FAIL send: byte %h not accepted within 64 cycles", b);
      end
   endtask

   task automatic send_stream(input vec_t v);
      logic [31:0] w;
      send_byte(v.len, v.gaps);
      for (int k = 0; k <= int'(v.len); k++) begin
         w = word_of(v.len, k);
         send_byte(w[31:24], v.gaps);
         send_byte(w[23:16], v.gaps);
         send_byte(w[15:8], v.gaps);
         send_byte(w[7:0], v.gaps);
      end
      send_byte(v.c, v.gaps);
   endtask

   task automatic finish_and_check(input vec_t v, input string tag);
      int n = int'(v.len) + 1;
      int bad = 0;
      logic [31:0] ed;
      for (int i = 0; i < 300; i++) begin
         rx_valid = v.gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         rx_data  = 8'hFF;
         @(posedge clk);
         #1;
      end
      rx_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_write_count"}, wa.size(), v.exp_writes);
      for (int i = 0; i < wa.size() && i < v.exp_writes; i++) begin
         ed = (i < n) ? word_of(v.len, i) : 32'h0;
         if (wa[i] !== 8'(i) || wd[i] !== ed) bad++;
      end
      chk({tag, "_write_seq_errors"}, bad, 0);
      chk({tag, "_start"}, start, v.exp_start);
      chk({tag, "_error"}, error, v.exp_code != 2'b00);
      chk({tag, "_err_code"}, err_code, v.exp_code);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_bytes_accepted"}, acc_cnt, 4 * n + 2);
      if (!v.exp_start) chk({tag, "_start_never"}, start_seen, 0);
      if (v.exp_start && !v.gaps) begin
         chk({tag, "_start_latency"}, start_cyc - last_we_cyc, 1);
         chk({tag, "_busy_at_last_write"}, busy_at_we, 1);
         chk({tag, "_busy_at_start"}, busy_at_start, 0);
      end
   endtask

   initial begin
      bit found;
      vecs[0] = '{8'h01, 8'hAA, 1'b0, 1'b1, 2'b00, 256};
      vecs[1] = '{8'hFF, 8'h00, 1'b0, 1'b1, 2'b00, 256};
      vecs[2] = '{8'h01, 8'hAB, 1'b0, 1'b0, 2'b01, 2};
      vecs[3] = '{8'h01, 8'hAA, 1'b1, 1'b1, 2'b00, 256};
      vecs[4] = '{8'h02, 8'h03, 1'b1, 1'b1, 2'b00, 256};

      do_reset();
      chk("reset_flags", {rx_ready, imem_we, start, busy, error, err_code}, 7'b1000000);
      chk("reset_addr", imem_addr, 0);
      chk("reset_data", imem_data, 0);

      for (int t = 0; t < 5; t++) begin
         do_reset();
         send_stream(vecs[t]);
         finish_and_check(vecs[t], $sformatf("vec%0d", t));
      end

      // Timeout: three bytes of a one-word load, then silence.
      do_reset();
      send_byte(8'h00, 1'b0);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h33, 1'b0);
      rx_valid = 1'b0;
      repeat (1023) @(posedge clk);
      #1;
      chk("timeout_not_yet", error, 0);
      @(posedge clk);
      #1;
      chk("timeout_error", error, 1);
      chk("timeout_code", err_code, 2'b10);
      chk("timeout_ready", rx_ready, 0);
      chk("timeout_start", start, 0);

      // Last byte arrives one cycle before the timeout would fire.
      do_reset();
      send_byte(8'h00, 1'b0);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h33, 1'b0);
      rx_valid = 1'b0;
      repeat (1023) @(posedge clk);
      #1;
      send_byte(8'h44, 1'b0);
      send_byte(8'h44, 1'b0);
      repeat (300) @(posedge clk);
      @(negedge clk);
      chk("edge_timeout_start", start, 1);
      chk("edge_timeout_error", error, 0);
      chk("edge_timeout_word0", (wd.size() > 0) ? wd[0] : 32'hDEADBEEF, 32'h11223344);
      chk("edge_timeout_writes", wa.size(), 256);

      // Reset while the zero-fill is at address 100.
      do_reset();
      send_stream(vecs[0]);
      rx_valid = 1'b1;
      rx_data  = 8'hFF;
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         @(negedge clk);
         if (imem_we && imem_addr == 8'd100) found = 1'b1;
      end
      chk("midfill_reached_100", found, 1);
      rst_n = 1'b0;
      #1;
      chk("midfill_reset_flags", {rx_ready, imem_we, start, busy, error, err_code}, 7'b1000000);
      chk("midfill_reset_addr", imem_addr, 0);
      do_reset();
      send_stream(vecs[0]);
      finish_and_check(vecs[0], "after_reset");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
